// File: rtl/ps2_pkg.sv
// Shared constants, prefix-state type and frame check helper for the PS/2 keycode receiver.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } prefix_state_t;

  // Start low, odd parity over data+parity, stop high.
  function automatic logic frame_ok(input logic start, input logic [7:0] data,
                                    input logic parity, input logic stop);
    return !start && (^{data, parity}) && stop;
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame deserializer: synchronizers, falling-edge detect, 11-bit shift, frame check, timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] data_byte,
  output logic       byte_valid,
  output logic       byte_err
);

  localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]     LAST_BIT = 4'(PS2_FRAME_BITS - 1);

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_prev;
  logic                   clk_s;
  logic                   data_s;
  logic                   fall;
  logic [3:0]             bit_cnt;
  logic [9:0]             shreg;
  logic [TW-1:0]          to_cnt;
  logic                   timeout_hit;
  logic                   frame_done;
  logic                   good;

  // Synchronizers idle high so reset release never looks like a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_s;
    end
  end

  assign clk_s       = clk_sync[SYNC_STAGES-1];
  assign data_s      = data_sync[SYNC_STAGES-1];
  assign fall        = clk_prev && !clk_s;
  assign timeout_hit = (bit_cnt != 4'd0) && !fall && (to_cnt == TO_LAST);

  // Bits 0..9 shift in LSB-first; the stop bit is judged live at bit 10.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt <= 4'd0;
      shreg   <= 10'd0;
      to_cnt  <= '0;
    end else if (fall) begin
      to_cnt <= '0;
      if (bit_cnt == LAST_BIT) begin
        bit_cnt <= 4'd0;
      end else begin
        bit_cnt <= bit_cnt + 4'd1;
        shreg   <= {data_s, shreg[9:1]};
      end
    end else if (bit_cnt != 4'd0) begin
      if (timeout_hit) begin
        bit_cnt <= 4'd0;
        to_cnt  <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  assign frame_done = fall && (bit_cnt == LAST_BIT);
  assign good       = frame_ok(shreg[0], shreg[8:1], shreg[9], data_s);
  assign data_byte  = shreg[8:1];
  assign byte_valid = frame_done && good;
  assign byte_err   = (frame_done && !good) || timeout_hit;

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 scan-code set 2 receiver: resolves E0/F0 prefixes into keycode/key_make/key_ext.
// Optional build macro TYPEMATIC_FILTER_EN suppresses repeated makes of a held key.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0]    data_byte;
  logic          byte_valid;
  logic          byte_err;
  prefix_state_t state;
  prefix_state_t state_n;
  logic          emit;
  logic          make_n;
  logic          ext_n;
  logic          repeat_hit;

  ps2_frame_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_frame (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .data_byte  (data_byte),
    .byte_valid (byte_valid),
    .byte_err   (byte_err)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    emit    = 1'b0;
    make_n  = 1'b0;
    ext_n   = 1'b0;
    if (byte_err) begin
      state_n = IDLE;
    end else if (byte_valid) begin
      case (data_byte)
        PS2_EXT_PREFIX: state_n = (state == BRK || state == EXT_BRK) ? EXT_BRK : EXT;
        PS2_BRK_PREFIX: state_n = (state == EXT || state == EXT_BRK) ? EXT_BRK : BRK;
        default: begin
          emit    = 1'b1;
          make_n  = !(state == BRK || state == EXT_BRK);
          ext_n   = (state == EXT || state == EXT_BRK);
          state_n = IDLE;
        end
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic       held;
  logic [8:0] held_key;

  assign repeat_hit = emit && make_n && held && (held_key == {ext_n, data_byte});

  // A break clears the held key; a new make replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      held     <= 1'b0;
      held_key <= 9'd0;
    end else if (emit && !repeat_hit) begin
      held     <= make_n;
      held_key <= {ext_n, data_byte};
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      keycode   <= 8'd0;
      key_make  <= 1'b0;
      key_ext   <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= emit && !repeat_hit;
      frame_err <= byte_err;
      if (emit && !repeat_hit) begin
        keycode  <= data_byte;
        key_make <= make_n;
        key_ext  <= ext_n;
      end
    end
  end

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Self-checking bench for ps2_keycode_rx: drives PS/2 frames, scoreboards the key triples.
module tb_ps2_keycode_rx;

  localparam int SYNC_STAGES    = 2;
  localparam int TIMEOUT_CYCLES = 200;
  localparam int HALF           = 10;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_make;
  logic       key_ext;
  logic       key_valid;
  logic       frame_err;

  ps2_keycode_rx #(
    .SYNC_STAGES    (SYNC_STAGES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .keycode   (keycode),
    .key_make  (key_make),
    .key_ext   (key_ext),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- scoreboard state ----
  logic [9:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int valid_cnt = 0, err_cnt = 0, pushed = 0;
  int base_valid = 0, base_err = 0, base_pushed = 0;
  int stop_fall_cyc = 0, last_fall_cyc = 0, err_cyc = 0;
`ifdef TYPEMATIC_FILTER_EN
  logic       m_held = 1'b0;
  logic [8:0] m_key  = 9'd0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---- output monitor ----
  always @(negedge clk) begin
    if (!reset) begin
      if (key_valid || frame_err)
        check("valid_err_overlap", 32'(key_valid & frame_err), 32'd0);
      if (key_valid) begin
        valid_cnt++;
        check("valid_latency", 32'(cyc - stop_fall_cyc), 32'(SYNC_STAGES + 1));
        check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0)
          check("key_triple", {22'd0, keycode, key_make, key_ext}, {22'd0, exp_q.pop_front()});
      end
      if (frame_err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  // ---- driver tasks ----
  task automatic do_reset();
    reset    = 1'b1;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
`ifdef TYPEMATIC_FILTER_EN
    m_held = 1'b0;
`endif
    repeat (SYNC_STAGES + 2) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b, input bit is_stop);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    if (is_stop) stop_fall_cyc = cyc;
    repeat (HALF) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par,
                                             input logic stop);
    return {stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int i = 0; i < n; i++) ps2_bit(frame[i], i == 10);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(make_frame(b, 1'b0, 1'b1), 11);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic expect_key(input logic [7:0] code, input logic mk, input logic ex);
`ifdef TYPEMATIC_FILTER_EN
    if (mk && m_held && m_key == {ex, code}) return;
    m_held = mk;
    m_key  = {ex, code};
`endif
    exp_q.push_back({code, mk, ex});
    pushed++;
  endtask

  task automatic send_key(input logic [7:0] code, input logic ex, input logic brk);
    if (ex)  send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    expect_key(code, !brk, ex);
    send_byte(code);
  endtask

  task automatic settle(input string tag, input int exp_err);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_valid_count"}, 32'(valid_cnt - base_valid), 32'(pushed - base_pushed));
    check({tag, "_err_count"}, 32'(err_cnt - base_err), 32'(exp_err));
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    base_valid  = valid_cnt;
    base_err    = err_cnt;
    base_pushed = pushed;
  endtask

  // ---- stimulus ----
  initial begin
    int v0;
    int waited;
    logic [7:0] rb;
    logic [7:0] typ_seq [6];
    do_reset();
    check("rst_keycode", 32'(keycode), 32'd0);
    check("rst_make", 32'(key_make), 32'd0);
    check("rst_ext", 32'(key_ext), 32'd0);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_bit_cnt", 32'(dut.u_frame.bit_cnt), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);

    send_key(8'h1D, 1'b0, 1'b0);
    settle("make_1d", 0);

    send_byte(8'hF0);
    settle("brk_prefix_only", 0);
    expect_key(8'h1D, 1'b0, 1'b0);
    send_byte(8'h1D);
    settle("break_1d", 0);

    send_byte(8'hE0);
    send_byte(8'hF0);
    settle("ext_brk_prefixes", 0);
    expect_key(8'h75, 1'b0, 1'b1);
    send_byte(8'h75);
    settle("ext_break_75", 0);
    send_key(8'h75, 1'b0, 1'b0);
    settle("plain_make_75", 0);

    send_bits(make_frame(8'h1D, 1'b1, 1'b1), 11);
    settle("bad_parity", 1);
    send_key(8'h1C, 1'b0, 1'b0);
    settle("after_parity_err", 0);

    // A dangling prefix must be wiped by a bad stop bit.
    send_byte(8'hF0);
    send_bits(make_frame(8'h1D, 1'b0, 1'b0), 11);
    settle("bad_stop", 1);
    send_key(8'h1B, 1'b0, 1'b0);
    settle("after_stop_err", 0);

    send_bits(make_frame(8'h29, 1'b0, 1'b1), 4);
    repeat (4) @(posedge clk);
    #1 check("timeout_partial_cnt", 32'(dut.u_frame.bit_cnt), 32'd4);
    v0 = err_cnt;
    waited = 0;
    while (err_cnt == v0 && waited < 2 * TIMEOUT_CYCLES) begin
      @(posedge clk);
      waited++;
    end
    check("timeout_seen", 32'(err_cnt != v0), 32'd1);
    check("timeout_delay_window",
          32'((err_cyc - last_fall_cyc) >= TIMEOUT_CYCLES &&
              (err_cyc - last_fall_cyc) <= TIMEOUT_CYCLES + SYNC_STAGES + 4), 32'd1);
    #1 check("timeout_bit_cnt", 32'(dut.u_frame.bit_cnt), 32'd0);
    settle("timeout", 1);
    send_key(8'h29, 1'b0, 1'b0);
    settle("after_timeout", 0);

    send_bits(make_frame(8'h34, 1'b0, 1'b1), 5);
    do_reset();
    check("midreset_bit_cnt", 32'(dut.u_frame.bit_cnt), 32'd0);
    settle("mid_frame_reset", 0);
    send_key(8'h34, 1'b0, 1'b0);
    settle("after_mid_reset", 0);

    do_reset();
    settle("pre_typematic", 0);
    typ_seq = '{8'h1D, 8'h1D, 8'h1D, 8'hF0, 8'h1D, 8'h1D};
    v0 = valid_cnt;
    for (int i = 0; i < 6; i++) begin
      if (typ_seq[i] != 8'hF0) expect_key(typ_seq[i], !(i == 4), 1'b0);
      send_byte(typ_seq[i]);
    end
    settle("typematic", 0);
`ifdef TYPEMATIC_FILTER_EN
    check("typematic_count", 32'(valid_cnt - v0), 32'd3);
`else
    check("typematic_count", 32'(valid_cnt - v0), 32'd5);
`endif

    for (int i = 0; i < 8; i++) begin
      rb = 8'($urandom_range(0, 255));
      if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h1A;
      send_key(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    settle("random_keys", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
